// File: rtl/game_timer_pkg.sv
// Shared types, digit limits and active-low 7-segment patterns for the game timer.
package game_timer_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t UNITS_MAX = 4'd9;
    localparam bcd_t TENS_MAX  = 4'd5;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}; anything outside 0..9 is shown blank.
    function automatic logic [6:0] seg_pattern(input bcd_t d);
        logic [6:0] pat;
        case (d)
            4'd0:    pat = 7'h40;
            4'd1:    pat = 7'h79;
            4'd2:    pat = 7'h24;
            4'd3:    pat = 7'h30;
            4'd4:    pat = 7'h19;
            4'd5:    pat = 7'h12;
            4'd6:    pat = 7'h02;
            4'd7:    pat = 7'h78;
            4'd8:    pat = 7'h00;
            4'd9:    pat = 7'h10;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD counter digit with a configurable maximum, ripple carry/borrow and clamped load.
module bcd_digit_cell
    import game_timer_pkg::*;
#(
    parameter bcd_t MAX = UNITS_MAX
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    input  logic ld,
    input  bcd_t ld_val,
    output bcd_t q,
    output logic carry,
    output logic borrow
);

    bcd_t r_q_r;

    assign q      = r_q_r;
    assign carry  = inc & (r_q_r == MAX);
    assign borrow = dec & (r_q_r == 4'd0);

    // Digit register: load (clamped to MAX) wins over increment/decrement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q_r <= 4'd0;
        end else if (ld) begin
            r_q_r <= (ld_val > MAX) ? MAX : ld_val;
        end else if (inc) begin
            r_q_r <= (r_q_r == MAX) ? 4'd0 : r_q_r + 4'd1;
        end else if (dec) begin
            r_q_r <= (r_q_r == 4'd0) ? MAX : r_q_r - 4'd1;
        end else begin
            r_q_r <= r_q_r;
        end
    end

endmodule

// File: rtl/hex7seg.sv
// Combinational digit to active-low 7-segment decoder.
module hex7seg
    import game_timer_pkg::*;
(
    input  bcd_t       hex,
    output logic [6:0] seg
);

    assign seg = seg_pattern(hex);

endmodule

// File: rtl/game_timer_disp.sv
// Seconds-based up/down game timer with sticky expiry and a multiplexed 7-seg driver.
// Optional lap-freeze display enabled by defining TIMER_LAP_EN.
module game_timer_disp
    import game_timer_pkg::*;
#(
    parameter int FRAMES_PER_SEC = 60,
    parameter int NUM_DIGITS     = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    frame,
    input  logic                    run,
    input  logic                    down,
    input  logic                    clear,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] preset,
    input  logic                    digsel,
    input  logic                    flash,
    input  logic                    f_clk,
    input  logic                    lap,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic                    expired,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg
);

    localparam int PW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(FRAMES_PER_SEC - 1);
    localparam logic [NUM_DIGITS-1:0] RING_INIT = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

    logic [PW-1:0]           r_presc_r;
    logic                    r_expired_r;
    logic [NUM_DIGITS-1:0]   r_ring_r;
    logic [NUM_DIGITS-1:0]   r_an_r;
    logic [6:0]              r_seg_r;

    logic                    w_adv_s;
    logic                    w_cnt_s;
    logic                    w_up_tick_s;
    logic                    w_dn_tick_s;
    logic                    w_all_max_s;
    logic                    w_all_zero_s;
    logic                    w_one_s;
    logic                    w_ld_s;
    logic                    w_expired_nxt_s;
    logic [NUM_DIGITS-1:0]   w_inc_s;
    logic [NUM_DIGITS-1:0]   w_dec_s;
    logic [NUM_DIGITS-1:0]   w_carry_s;
    logic [NUM_DIGITS-1:0]   w_borrow_s;
    logic [NUM_DIGITS-1:0]   w_at_max_s;
    logic [NUM_DIGITS-1:0]   w_at_zero_s;
    logic [NUM_DIGITS-1:0]   w_ring_nxt_s;
    logic [4*NUM_DIGITS-1:0] w_disp_s;
    bcd_t                    w_sel_s;
    logic [6:0]              w_seg_s;

    // Prescaler only runs on counted frames; an expired timer stops it too.
    assign w_adv_s      = frame & run & ~r_expired_r;
    assign w_cnt_s      = w_adv_s & (r_presc_r == PRESC_MAX) & ~clear & ~load;
    assign w_all_max_s  = &w_at_max_s;
    assign w_all_zero_s = &w_at_zero_s;
    assign w_one_s      = (bcd[3:0] == 4'd1) & (&w_at_zero_s[NUM_DIGITS-1:1]);
    assign w_up_tick_s  = w_cnt_s & ~down & ~w_all_max_s;
    assign w_dn_tick_s  = w_cnt_s & down & ~w_all_zero_s;
    assign w_ld_s       = clear | load;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            localparam bcd_t CELL_MAX = (gi % 2 == 0) ? UNITS_MAX : TENS_MAX;
            bcd_t w_ldv_s;

            if (gi == 0) begin : g_lsd
                assign w_inc_s[gi] = w_up_tick_s;
                assign w_dec_s[gi] = w_dn_tick_s;
            end else begin : g_upper
                assign w_inc_s[gi] = w_carry_s[gi-1];
                assign w_dec_s[gi] = w_borrow_s[gi-1];
            end

            assign w_ldv_s         = clear ? 4'd0 : preset[4*gi +: 4];
            assign w_at_max_s[gi]  = (bcd[4*gi +: 4] == CELL_MAX);
            assign w_at_zero_s[gi] = (bcd[4*gi +: 4] == 4'd0);

            bcd_digit_cell #(
                .MAX (CELL_MAX)
            ) u_cell (
                .clk    (clk),
                .rst_n  (reset_n),
                .inc    (w_inc_s[gi]),
                .dec    (w_dec_s[gi]),
                .ld     (w_ld_s),
                .ld_val (w_ldv_s),
                .q      (bcd[4*gi +: 4]),
                .carry  (w_carry_s[gi]),
                .borrow (w_borrow_s[gi])
            );
        end
    endgenerate

    // Frame prescaler: zeroed by clear/load, wraps after the last frame of a second.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_presc_r <= '0;
        end else if (w_ld_s) begin
            r_presc_r <= '0;
        end else if (w_adv_s) begin
            r_presc_r <= (r_presc_r == PRESC_MAX) ? '0 : r_presc_r + PW'(1'b1);
        end else begin
            r_presc_r <= r_presc_r;
        end
    end

    // Expiry: at max going up, or at/reaching zero going down.
    always_comb begin
        w_expired_nxt_s = r_expired_r;
        if (w_ld_s) begin
            w_expired_nxt_s = 1'b0;
        end else if (w_cnt_s & ((~down & w_all_max_s) | (down & (w_all_zero_s | w_one_s)))) begin
            w_expired_nxt_s = 1'b1;
        end else begin
            w_expired_nxt_s = r_expired_r;
        end
    end

    // Sticky expiry register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_expired_r <= 1'b0;
        end else begin
            r_expired_r <= w_expired_nxt_s;
        end
    end

    assign expired = r_expired_r;

`ifdef TIMER_LAP_EN
    logic r_lap_d_r;
    logic r_lap_act_r;
    logic [4*NUM_DIGITS-1:0] r_lap_val_r;

    // Lap capture: snapshot on the rising edge, shown until lap drops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lap_d_r   <= 1'b0;
            r_lap_act_r <= 1'b0;
            r_lap_val_r <= '0;
        end else begin
            r_lap_d_r <= lap;
            if (lap & ~r_lap_d_r) begin
                r_lap_val_r <= bcd;
                r_lap_act_r <= 1'b1;
            end else if (!lap) begin
                r_lap_act_r <= 1'b0;
            end else begin
                r_lap_act_r <= r_lap_act_r;
            end
        end
    end

    assign w_disp_s = r_lap_act_r ? r_lap_val_r : bcd;
`else
    logic w_lap_unused_s;
    assign w_lap_unused_s = lap;
    assign w_disp_s       = bcd;
`endif

    // Digit ring advances one position per refresh strobe.
    always_comb begin
        w_ring_nxt_s = r_ring_r;
        if (digsel) begin
            w_ring_nxt_s = {r_ring_r[NUM_DIGITS-2:0], r_ring_r[NUM_DIGITS-1]};
        end else begin
            w_ring_nxt_s = r_ring_r;
        end
    end

    // Digit mux driven by the upcoming ring so anode and segments switch together.
    always_comb begin
        w_sel_s = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_sel_s = w_sel_s | (w_disp_s[4*i +: 4] & {4{w_ring_nxt_s[i]}});
        end
    end

    hex7seg u_hex7seg (
        .hex (w_sel_s),
        .seg (w_seg_s)
    );

    // Ring and registered display outputs; blanking gates anodes only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ring_r <= RING_INIT;
            r_an_r   <= ~RING_INIT;
            r_seg_r  <= seg_pattern(4'd0);
        end else begin
            r_ring_r <= w_ring_nxt_s;
            r_an_r   <= ~(w_ring_nxt_s & {NUM_DIGITS{~flash | f_clk}});
            r_seg_r  <= w_seg_s;
        end
    end

    assign an  = r_an_r;
    assign seg = r_seg_r;

endmodule

// File: tb/tb_game_timer_disp.sv
// Directed self-checking bench for game_timer_disp (FRAMES_PER_SEC=60, NUM_DIGITS=4).
module tb_game_timer_disp;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        frame, run, down, clear, load, digsel, flash, f_clk, lap;
    logic [15:0] preset;
    logic [15:0] bcd;
    logic        expired;
    logic [3:0]  an;
    logic [6:0]  seg;

    int n_tests = 0;
    int n_fail  = 0;

    game_timer_disp #(
        .FRAMES_PER_SEC (60),
        .NUM_DIGITS     (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .frame   (frame),
        .run     (run),
        .down    (down),
        .clear   (clear),
        .load    (load),
        .preset  (preset),
        .digsel  (digsel),
        .flash   (flash),
        .f_clk   (f_clk),
        .lap     (lap),
        .bcd     (bcd),
        .expired (expired),
        .an      (an),
        .seg     (seg)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) begin
            frame = 1'b1;
            @(posedge clk); #1;
            frame = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        preset = v;
        load   = 1'b1;
        @(posedge clk); #1;
        load   = 1'b0;
    endtask

    task automatic pulse_digsel();
        digsel = 1'b1;
        @(posedge clk); #1;
        digsel = 1'b0;
        @(posedge clk); #1;
    endtask

    logic [3:0] an_exp [4]  = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    logic [6:0] seg_exp [4] = '{7'h30, 7'h24, 7'h79, 7'h19};

    initial begin
        reset_n = 1'b0;
        {frame, run, down, clear, load, digsel, flash, f_clk, lap} = 9'b0;
        preset  = 16'h0000;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;

        check_eq("rst_bcd", 32'(bcd), 32'h0000);
        check_eq("rst_exp", 32'(expired), 32'h0);
        check_eq("rst_an", 32'(an), 32'hE);
        check_eq("rst_seg", 32'(seg), 32'h40);

        // One second from 60 frames
        run = 1'b1;
        frames(59);
        check_eq("up_59f", 32'(bcd), 32'h0000);
        frames(1);
        check_eq("up_60f", 32'(bcd), 32'h0001);

        // Pause mid-second
        frames(30);
        run = 1'b0;
        frames(30);
        check_eq("pause_hold", 32'(bcd), 32'h0001);
        run = 1'b1;
        frames(29);
        check_eq("resume_29", 32'(bcd), 32'h0001);
        frames(1);
        check_eq("resume_30", 32'(bcd), 32'h0002);

        // Clear beats load; clamped preset
        preset = 16'h1234;
        clear  = 1'b1;
        load   = 1'b1;
        @(posedge clk); #1;
        clear  = 1'b0;
        load   = 1'b0;
        check_eq("clr_over_ld", 32'(bcd), 32'h0000);
        do_load(16'h0A7F);
        check_eq("ld_clamp", 32'(bcd), 32'h0959);
        do_load(16'h1234);
        check_eq("ld_plain", 32'(bcd), 32'h1234);

        // Count up to max and hold
        do_load(16'h5958);
        frames(60);
        check_eq("up_to_max", 32'(bcd), 32'h5959);
        check_eq("up_no_exp", 32'(expired), 32'h0);
        frames(60);
        check_eq("up_hold", 32'(bcd), 32'h5959);
        check_eq("up_exp", 32'(expired), 32'h1);
        frames(60);
        check_eq("up_frozen", 32'(bcd), 32'h5959);

        // Countdown from one minute
        do_load(16'h0100);
        check_eq("ld_clr_exp", 32'(expired), 32'h0);
        down = 1'b1;
        frames(60);
        check_eq("dn_borrow", 32'(bcd), 32'h0059);
        frames(59 * 60);
        check_eq("dn_zero", 32'(bcd), 32'h0000);
        check_eq("dn_exp", 32'(expired), 32'h1);
        frames(60);
        check_eq("dn_hold", 32'(bcd), 32'h0000);

        // Down tick while already zero
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check_eq("clr_exp", 32'(expired), 32'h0);
        frames(60);
        check_eq("dn0_bcd", 32'(bcd), 32'h0000);
        check_eq("dn0_exp", 32'(expired), 32'h1);

        // Display ring and blanking
        down = 1'b0;
        run  = 1'b0;
        do_load(16'h1234);
        @(posedge clk); #1;
        check_eq("ring0_seg", 32'(seg), 32'h19);
        for (int i = 0; i < 4; i++) begin
            pulse_digsel();
            check_eq($sformatf("ring%0d_an", i + 1), 32'(an), 32'(an_exp[i]));
            check_eq($sformatf("ring%0d_seg", i + 1), 32'(seg), 32'(seg_exp[i]));
        end
        flash = 1'b1;
        f_clk = 1'b0;
        @(posedge clk); #1;
        check_eq("blank_an", 32'(an), 32'hF);
        check_eq("blank_seg", 32'(seg), 32'h19);
        f_clk = 1'b1;
        @(posedge clk); #1;
        check_eq("flash_on_an", 32'(an), 32'hE);
        flash = 1'b0;
        f_clk = 1'b0;

        // Lap freeze
        run = 1'b1;
        lap = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        frames(180);
        check_eq("lap_bcd_live", 32'(bcd), 32'h1237);
`ifdef TIMER_LAP_EN
        check_eq("lap_seg_frozen", 32'(seg), 32'h19);
`else
        check_eq("lap_ignored_seg", 32'(seg), 32'h78);
`endif
        lap = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("lap_release_seg", 32'(seg), 32'h78);

        // Asynchronous reset mid-count
        #2 reset_n = 1'b0;
        #1;
        check_eq("arst_bcd", 32'(bcd), 32'h0000);
        check_eq("arst_an", 32'(an), 32'hE);
        check_eq("arst_seg", 32'(seg), 32'h40);
        reset_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
